// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input port with 2-flop sync, W1C edge capture and masked level irq.
// Optional per-bit debounce filter is compiled in when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_edge_irq #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned EDGE_MODE       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

`ifdef PIO_IN_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int unsigned WARM   = DB_EN ? 3 + DEBOUNCE_CYCLES : 3;
  localparam int unsigned WARM_W = $clog2(WARM + 1);

  logic [WIDTH-1:0]  s1_q, s2_q, f, f_dly_q;
  logic [WIDTH-1:0]  edge_det, clr;
  logic [WIDTH-1:0]  cap_q, cap_d, mask_q, mask_d, readdata_q, readdata_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              wr, cap_en;

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0]            f_q, f_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // f follows s2 only after s2 has differed from f for DEBOUNCE_CYCLES consecutive edges
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        f_d[i]   = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q   <= '0;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f = f_q;
`else
  assign f = s2_q;
`endif

  always_comb begin
    case (EDGE_MODE)
      0:       edge_det = f & ~f_dly_q;
      1:       edge_det = ~f & f_dly_q;
      default: edge_det = f ^ f_dly_q;
    endcase
  end

  assign wr     = chipselect && !write_n;
  assign cap_en = (warm_q == WARM_W'(WARM));
  assign warm_d = cap_en ? warm_q : warm_q + WARM_W'(1);
  assign clr    = (wr && address == 2'd3) ? writedata : '0;
  // set has priority over a same-cycle W1C clear
  assign cap_d  = (cap_q & ~clr) | (cap_en ? edge_det : '0);
  assign mask_d = (wr && address == 2'd2) ? writedata : mask_q;

  always_comb begin
    case (address)
      2'd0:    readdata_d = f;
      2'd2:    readdata_d = mask_q;
      2'd3:    readdata_d = cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      f_dly_q    <= '0;
      cap_q      <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      warm_q     <= '0;
    end else begin
      s1_q       <= in_port;
      s2_q       <= s1_q;
      f_dly_q    <= f;
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      warm_q     <= warm_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Scoreboard bench for pio_in_edge_irq: a rising-edge and an any-edge instance share bus and inputs.
module tb_pio_in_edge_irq;

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DBL = 4;
`else
  localparam int DBL = 0;
`endif
  localparam int LAT   = 3 + DBL;  // edges from driving in_port to EDGECAP set
  localparam int WARMW = 6 + DBL;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic [1:0] address = '0;
  logic [1:0] writedata = '0;
  logic [1:0] in_port = '0;
  logic [1:0] rd_r, rd_a;
  logic       irq_r, irq_a;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(2), .EDGE_MODE(0), .DEBOUNCE_CYCLES(4)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r));

  pio_in_edge_irq #(.WIDTH(2), .EDGE_MODE(2), .DEBOUNCE_CYCLES(4)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a));

  typedef struct {
    string      tag;
    int         kind;
    logic [1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [1:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       chk(e.tag, rd_r, e.exp);
        1:       chk(e.tag, rd_a, e.exp);
        2:       chk(e.tag, {1'b0, irq_r}, e.exp);
        default: chk(e.tag, {1'b0, irq_a}, e.exp);
      endcase
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [1:0] er, input logic [1:0] ea);
    address = a;
    push({tag, "_rise"}, 0, er);
    push({tag, "_any"}, 1, ea);
    step(1);
    drain();
  endtask

  task automatic irqs(input string tag, input logic er, input logic ea);
    push({tag, "_irq_rise"}, 2, {1'b0, er});
    push({tag, "_irq_any"}, 3, {1'b0, ea});
    drain();
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_port = 2'b11;
    step(2);
    rd("in_reset", 2'd0, 2'b00, 2'b00);
    irqs("in_reset", 1'b0, 1'b0);
    reset_n = 1'b1;
    step(WARMW);
    rd("warm_data", 2'd0, 2'b11, 2'b11);
    rd("warm_cap", 2'd3, 2'b00, 2'b00);
    irqs("warm", 1'b0, 1'b0);
    wr(2'd1, 2'b11);
    rd("rsvd", 2'd1, 2'b00, 2'b00);

    wr(2'd2, 2'b01);
    rd("mask01", 2'd2, 2'b01, 2'b01);
    irqs("mask01", 1'b0, 1'b0);

    in_port = 2'b00;
    step(LAT - 1);
    irqs("fall_early", 1'b0, 1'b0);
    step(1);
    irqs("fall", 1'b0, 1'b1);
    rd("fall_cap", 2'd3, 2'b00, 2'b11);

    wr(2'd3, 2'b11);
    irqs("clr", 1'b0, 1'b0);
    rd("clr_cap", 2'd3, 2'b00, 2'b00);

    in_port = 2'b01;
    step(LAT - 1);
    irqs("rise_early", 1'b0, 1'b0);
    step(1);
    irqs("rise", 1'b1, 1'b1);
    rd("rise_cap", 2'd3, 2'b01, 2'b01);
    wr(2'd3, 2'b01);
    irqs("clr2", 1'b0, 1'b0);

    wr(2'd2, 2'b00);
    in_port = 2'b11;
    step(LAT + 1);
    irqs("masked", 1'b0, 1'b0);
    rd("masked_cap", 2'd3, 2'b10, 2'b10);
    wr(2'd2, 2'b10);
    irqs("unmask", 1'b1, 1'b1);

    wr(2'd2, 2'b01);
    irqs("remask", 1'b0, 1'b0);
    in_port = 2'b10;
    step(LAT + 1);
    irqs("g_fall", 1'b0, 1'b1);
    in_port = 2'b11;
    step(LAT + 1);
    irqs("g_rise", 1'b1, 1'b1);
    in_port = 2'b10;
    step(LAT + 1);
    // new rising edge on bit0 lands on the same edge as its W1C clear
    in_port = 2'b11;
    step(LAT - 1);
    wr(2'd3, 2'b01);
    irqs("collide", 1'b1, 1'b1);
    rd("collide_cap", 2'd3, 2'b11, 2'b11);

    wr(2'd2, 2'b11);
    irqs("pre_rst", 1'b1, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    irqs("async_rst", 1'b0, 1'b0);
    push("async_rst_rd_rise", 0, 2'b00);
    push("async_rst_rd_any", 1, 2'b00);
    drain();
    step(2);
    reset_n = 1'b1;
    step(WARMW);
    rd("post_cap", 2'd3, 2'b00, 2'b00);
    rd("post_mask", 2'd2, 2'b00, 2'b00);
    rd("post_data", 2'd0, 2'b11, 2'b11);
    wr(2'd2, 2'b11);
    irqs("post", 1'b0, 1'b0);

    in_port = 2'b00;
    step(LAT + 1);
    irqs("final", 1'b0, 1'b1);
    rd("final_cap", 2'd3, 2'b00, 2'b11);

`ifdef PIO_IN_DEBOUNCE_EN
    wr(2'd3, 2'b11);
    in_port = 2'b01;
    step(3);
    in_port = 2'b00;
    step(12);
    rd("glitch_data", 2'd0, 2'b00, 2'b00);
    rd("glitch_cap", 2'd3, 2'b00, 2'b00);
    in_port = 2'b01;
    address = 2'd0;
    step(5);
    rd("db_early", 2'd0, 2'b00, 2'b00);
    rd("db_data", 2'd0, 2'b01, 2'b01);
    irqs("db", 1'b1, 1'b1);
    rd("db_cap", 2'd3, 2'b01, 2'b01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
